// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues in-order requests with up to DEPTH in flight,
// buffers returned words in a DEPTH-entry FIFO and presents the head to the IF/ID register.
module ifu_fetch #(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           DEPTH      = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [5:0]            stall_i,
   input  logic                  jump_i,
   input  logic [ADDR_WIDTH-1:0] jump_addr_i,
   input  logic                  int_i,
   input  logic [ADDR_WIDTH-1:0] int_addr_i,
   output logic                  ibus_req_o,
   output logic [ADDR_WIDTH-1:0] ibus_addr_o,
   input  logic                  ibus_gnt_i,
   input  logic                  ibus_rvalid_i,
   input  logic [DATA_WIDTH-1:0] ibus_rdata_i,
   output logic                  inst_valid_o,
   output logic [ADDR_WIDTH-1:0] inst_addr_o,
   output logic [DATA_WIDTH-1:0] inst_o
);
   localparam int unsigned           PW      = $clog2(DEPTH);
   localparam int unsigned           CW      = PW + 1;
   localparam int unsigned           STOP    = 1;
   localparam logic [CW:0]           DEPTH_W = (CW + 1)'(DEPTH);
   localparam logic [DATA_WIDTH-1:0] NOP     = DATA_WIDTH'(32'h0000_0013);
   localparam logic [ADDR_WIDTH-1:0] INC     = ADDR_WIDTH'(4);

   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [ADDR_WIDTH-1:0] push_addr_q, push_addr_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [CW-1:0]         out_cnt_q, out_cnt_d;
   logic [CW-1:0]         drop_cnt_q, drop_cnt_d;

   logic [ADDR_WIDTH-1:0] mem_addr_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_data_q [DEPTH];

   logic                  redirect;
   logic [ADDR_WIDTH-1:0] target;
   logic [CW:0]           in_use;
   logic                  req;
   logic                  grant;
   logic                  resp;
   logic                  drop;
   logic                  push;
   logic                  valid;
   logic                  pop;
   logic                  unused_stall;

   assign unused_stall = ^{stall_i[5:2], stall_i[0]};

   always_comb begin
      redirect = int_i | jump_i;
      target   = int_i ? int_addr_i : jump_addr_i;
      in_use   = {1'b0, out_cnt_q} + {1'b0, count_q};
      // Every granted request owns a FIFO slot, so a push can never find the FIFO full.
      req      = rst_ni & ~redirect & (in_use < DEPTH_W);
      grant    = req & ibus_gnt_i;
      resp     = ibus_rvalid_i & (out_cnt_q != '0);
      drop     = resp & (drop_cnt_q != '0);
      push     = resp & ~drop & ~redirect;
      valid    = (count_q != '0) & ~redirect;
      pop      = valid & ~stall_i[STOP];
   end

   always_comb begin
      pc_d        = pc_q;
      push_addr_d = push_addr_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      out_cnt_d   = out_cnt_q + CW'(grant) - CW'(resp);
      drop_cnt_d  = drop_cnt_q;
      if (redirect) begin
         pc_d        = target;
         push_addr_d = target;
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         // Everything still outstanding after this cycle belongs to the old stream.
         drop_cnt_d  = out_cnt_d;
      end else begin
         if (grant) begin
            pc_d = pc_q + INC;
         end
         if (drop) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
         end
         if (push) begin
            push_addr_d = push_addr_q + INC;
            wr_ptr_d    = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pc_q        <= RESET_PC;
         push_addr_q <= RESET_PC;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         out_cnt_q   <= '0;
         drop_cnt_q  <= '0;
      end else begin
         pc_q        <= pc_d;
         push_addr_q <= push_addr_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         out_cnt_q   <= out_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   // Payload storage needs no reset: count_q alone decides what is visible.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_addr_q[wr_ptr_q] <= push_addr_q;
         mem_data_q[wr_ptr_q] <= ibus_rdata_i;
      end
   end

   assign ibus_req_o   = req;
   assign ibus_addr_o  = pc_q;
   assign inst_valid_o = valid;
   assign inst_addr_o  = valid ? mem_addr_q[rd_ptr_q] : '0;
   assign inst_o       = valid ? mem_data_q[rd_ptr_q] : NOP;

endmodule
